// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the PS/2 keyboard receiver: register map, STATUS layout, frame FSM states.
// No logic; imported by ps2_kbd_if.
// Odd-parity helper gives the parity bit a device sends for a data byte.
package ps2_kbd_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int ST_NEMPTY   = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_OVF      = 2;
    localparam int ST_ERR      = 3;
    localparam int ST_CNT_LSB  = 4;
    localparam int CTRL_EN     = 0;
    localparam int DATA_VLD_BIT = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } frame_state_t;

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous scan-code FIFO with occupancy count.
// Latency: push visible at head one cycle later; pop advances head on the same edge.
// Backpressure: push while full is dropped unless a pop happens on the same edge.
module ps2_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ps2_kbd_if.sv
// PS/2 device-to-host receiver with scan-code FIFO behind a DATA/STATUS/CTRL register bus.
// Latency: ps2_clk fall to sample 2+FILT_LEN cycles; stop bit to NEMPTY 1 cycle; reads combinational.
// Backpressure: none on the PS/2 side; a full FIFO drops new codes and sets sticky OVF.
module ps2_kbd_if
    import ps2_kbd_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 100000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              rw_rnw,
    input  logic [1:0]        rw_addr,
    input  logic [DATA_W-1:0] data_to_wr,
    output logic [DATA_W-1:0] data_to_rd,
    input  logic              ps2_clk,
    input  logic              ps2_data
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    frame_state_t  state, state_nxt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_ok;
    logic [TW-1:0] tmo_cnt;
    logic          timeout;
    logic          frame_ok, frame_err;

    logic          en, ovf, err;
    logic          fifo_pop, fifo_full, fifo_empty, ovf_set, w1c;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          unused_wr;

    assign unused_wr = ^data_to_wr;

    // Filtered level flips on the FILT_LEN-th consecutive differing sample; that edge is the sample point.
    assign fall = clk_filt & ~clk_s2 & (filt_cnt == FW'(FILT_LEN - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
            if (clk_s2 != clk_filt) begin
                if (filt_cnt == FW'(FILT_LEN - 1)) begin
                    clk_filt <= clk_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign timeout = (state != S_IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_nxt = state;
        frame_ok  = 1'b0;
        frame_err = 1'b0;
        if (!en) begin
            state_nxt = S_IDLE;
        end else if (timeout) begin
            state_nxt = S_IDLE;
            frame_err = 1'b1;
        end else if (fall) begin
            case (state)
                S_IDLE:   if (!dat_s2) state_nxt = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
                S_PARITY: state_nxt = S_STOP;
                S_STOP: begin
                    state_nxt = S_IDLE;
                    if (dat_s2 && par_ok) frame_ok  = 1'b1;
                    else                  frame_err = 1'b1;
                end
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_ok  <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= (state_nxt == S_IDLE || fall) ? '0 : tmo_cnt + TW'(1);
            if (fall) begin
                case (state)
                    S_IDLE: bit_cnt <= '0;
                    S_DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    S_PARITY: par_ok <= (dat_s2 == odd_par(shreg));
                    default: ;
                endcase
            end
        end
    end

    assign fifo_pop = sel & rw_rnw & (rw_addr == ADDR_DATA);
    assign w1c      = sel & ~rw_rnw & (rw_addr == ADDR_STATUS);
    // A coincident pop frees the slot, so a push into a full FIFO only overflows without one.
    assign ovf_set  = frame_ok & fifo_full & ~fifo_pop;

    ps2_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (frame_ok),
        .pop   (fifo_pop),
        .din   (shreg),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            en  <= 1'b1;
            ovf <= 1'b0;
            err <= 1'b0;
        end else begin
            ovf <= ovf_set   | (ovf & ~(w1c & data_to_wr[ST_OVF]));
            err <= frame_err | (err & ~(w1c & data_to_wr[ST_ERR]));
            if (sel && !rw_rnw && rw_addr == ADDR_CTRL) en <= data_to_wr[CTRL_EN];
        end
    end

    always_comb begin
        data_to_rd = '0;
        if (sel) begin
            case (rw_addr)
                ADDR_DATA: begin
                    if (!fifo_empty) begin
                        data_to_rd[DATA_VLD_BIT] = 1'b1;
                        data_to_rd[7:0]          = fifo_head;
                    end
                end
                ADDR_STATUS: begin
                    data_to_rd[ST_NEMPTY]          = ~fifo_empty;
                    data_to_rd[ST_FULL]            = fifo_full;
                    data_to_rd[ST_OVF]             = ovf;
                    data_to_rd[ST_ERR]             = err;
                    data_to_rd[ST_CNT_LSB +: CW]   = fifo_count;
                end
                ADDR_CTRL: data_to_rd[CTRL_EN] = en;
                default:   data_to_rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kbd_if.sv
// Randomised and directed PS/2 frames against a queue-based model; read expectations are scoreboarded.
module tb_ps2_kbd_if;

    localparam int DW    = 32;
    localparam int FL    = 4;
    localparam int TMO   = 300;
    localparam int DEPTH = 8;
    localparam int HALF  = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sel = 1'b0;
    logic          rw_rnw = 1'b0;
    logic [1:0]    rw_addr = 2'd0;
    logic [DW-1:0] data_to_wr = '0;
    logic [DW-1:0] data_to_rd;
    logic          ps2_clk = 1'b1;
    logic          ps2_data = 1'b1;

    always #5 clk = ~clk;

    ps2_kbd_if #(.DATA_W(DW), .FILT_LEN(FL), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .rw_rnw     (rw_rnw),
        .rw_addr    (rw_addr),
        .data_to_wr (data_to_wr),
        .data_to_rd (data_to_rd),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    logic [7:0]  mq[$];
    logic        m_ovf = 1'b0;
    logic        m_err = 1'b0;
    logic        m_en  = 1'b1;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s      = '0;
        s[0]   = (mq.size() != 0);
        s[1]   = (mq.size() == DEPTH);
        s[2]   = m_ovf;
        s[3]   = m_err;
        s[7:4] = 4'(mq.size());
        return s;
    endfunction

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic pbad, input logic sbad);
        return {~sbad, (~^d) ^ pbad, d, 1'b0};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [1:0] a, input string tag);
        logic [31:0] e;
        case (a)
            2'd0: if (mq.size() == 0) e = 32'h0; else e = 32'h100 | 32'(mq.pop_front());
            2'd1: e = m_status();
            2'd2: e = {31'b0, m_en};
            default: e = 32'h0;
        endcase
        exp_q.push_back(e);
        tag_q.push_back(tag);
        sel = 1'b1; rw_rnw = 1'b1; rw_addr = a;
        tick(1);
        sel = 1'b0; rw_rnw = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; rw_rnw = 1'b0; rw_addr = a; data_to_wr = d;
        tick(1);
        sel = 1'b0;
        if (a == 2'd1) begin
            if (d[2]) m_ovf = 1'b0;
            if (d[3]) m_err = 1'b0;
        end else if (a == 2'd2) begin
            m_en = d[0];
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] d, input logic pbad, input logic sbad);
        if (!m_en) return;
        if (pbad || sbad) m_err = 1'b1;
        else if (mq.size() == DEPTH) m_ovf = 1'b1;
        else mq.push_back(d);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbad, input logic sbad);
        logic [10:0] bits;
        bits = frame_bits(d, pbad, sbad);
        for (int i = 0; i < 11; i++) send_bit(bits[i]);
        ps2_data = 1'b1;
        tick(FL + 8);
        model_frame(d, pbad, sbad);
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] e;
        string       t;
        if (sel && rw_rnw) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_read got=%h need=<no pending expectation>", data_to_rd);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if (data_to_rd !== e) begin
                    miscompares++;
                    $display("FAIL %s got=%h need=%h", t, data_to_rd, e);
                end
            end
        end else if (!sel) begin
            vectors++;
            if (data_to_rd !== '0) begin
                miscompares++;
                $display("FAIL idle_rd_zero got=%h need=%h", data_to_rd, 32'h0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout need=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [10:0] bits;
        rst = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);

        bus_read(2'd1, "rst_status");
        bus_read(2'd2, "rst_ctrl");
        bus_read(2'd0, "rst_data");
        bus_read(2'd3, "rst_addr3");

        send_frame(8'h1C, 1'b0, 1'b0);
        bus_read(2'd1, "good_status");
        bus_read(2'd0, "good_data");
        bus_read(2'd1, "good_status_after");

        send_frame(8'h1C, 1'b1, 1'b0);
        bus_read(2'd1, "par_status");
        bus_write(2'd1, 32'h8);
        bus_read(2'd1, "par_w1c_status");

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
        bus_read(2'd1, "ovf_status");
        for (int i = 0; i < 9; i++) bus_read(2'd0, "ovf_drain");
        bus_read(2'd1, "ovf_sticky");
        bus_write(2'd1, 32'h4);

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
        tick(TMO + 50);
        m_err = 1'b1;
        bus_read(2'd1, "tmo_status");
        send_frame(8'hF0, 1'b0, 1'b0);
        bus_read(2'd0, "tmo_next_data");
        bus_write(2'd1, 32'h8);

        send_frame(8'h33, 1'b0, 1'b0);
        send_frame(8'h44, 1'b0, 1'b0);
        bits = frame_bits(8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(bits[i]);
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        mq.delete();
        m_ovf = 1'b0; m_err = 1'b0; m_en = 1'b1;
        bus_read(2'd1, "midrst_status");
        send_frame(8'h5A, 1'b0, 1'b0);
        bus_read(2'd0, "midrst_data");

        bus_write(2'd2, 32'h0);
        send_frame(8'h1C, 1'b0, 1'b0);
        bus_read(2'd1, "dis_status");
        bus_read(2'd2, "dis_ctrl");
        bus_write(2'd2, 32'h1);
        send_frame(8'h1C, 1'b0, 1'b0);
        bus_read(2'd0, "en_data");

        for (int i = 0; i < DEPTH; i++) send_frame(8'(8'h60 + i), 1'b0, 1'b0);
        bits = frame_bits(8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(bits[i]);
        ps2_data = 1'b1;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(2 + FL - 1);
        bus_read(2'd0, "coinc_pop");
        mq.push_back(8'h77);
        tick(HALF - (2 + FL));
        ps2_clk = 1'b1;
        tick(FL + 8);
        bus_read(2'd1, "coinc_status");
        for (int i = 0; i < DEPTH; i++) bus_read(2'd0, "coinc_drain");

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) bus_write(2'd2, {31'b0, 1'($urandom_range(0, 3) != 0)});
            send_frame(8'($urandom), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0));
            repeat ($urandom_range(0, 3)) bus_read(2'($urandom_range(0, 3)), "rand_read");
            if ($urandom_range(0, 4) == 0) bus_write(1'($urandom_range(0, 1)) ? 2'd1 : 2'd3, $urandom);
        end
        bus_write(2'd2, 32'h1);
        bus_read(2'd1, "final_status");
        for (int i = 0; i <= DEPTH; i++) bus_read(2'd0, "final_drain");

        tick(2);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_expect got=%0d need=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
